check_scoreboard: RTL

CHECK_SCOREBOARD -- requirements
Module: check_scoreboard

---
 rtl/check_scoreboard_pkg.sv | 26 ++
 rtl/check_scoreboard_fail_fifo.sv | 58 +++++
 rtl/check_scoreboard.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/check_scoreboard_pkg.sv
// Shared types and defaults for the check scoreboard.
// Holds the session FSM state enum, default sizes and a saturating adder.
package check_scoreboard_pkg;

   localparam logic [31:0] DEF_END_SIMULATION = 32'hffff;
   localparam int          DEF_FAIL_DEPTH     = 8;
   localparam int          DEF_ID_WIDTH       = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_REPORT,
      ST_DONE
   } state_e;

   // Counters stick at all-ones instead of wrapping.
   function automatic logic [31:0] sat_add(
      input logic [31:0] a,
      input logic [1:0]  inc
   );
      logic [32:0] s;
      s = {1'b0, a} + {31'b0, inc};
      return s[32] ? 32'hffff_ffff : s[31:0];
   endfunction

endpackage

// File: rtl/check_scoreboard_fail_fifo.sv
// Synchronous FIFO holding failing check IDs.
// Ports: clk, rst, clr (flush), push/din, pop/dout, empty, full.
module fail_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_cnt;
   logic             w_pop;
   logic             w_push;

   assign empty = (r_cnt == '0);
   assign full  = (r_cnt == CNT_FULL);
   assign dout  = r_mem[r_rd];

   // A pop frees a slot in the same cycle, so push+pop on full succeeds.
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + PTR_ONE;
         if (w_pop)  r_rd <= r_rd + PTR_ONE;
         if (w_push && !w_pop)
            r_cnt <= r_cnt + CNT_ONE;
         else if (w_pop && !w_push)
            r_cnt <= r_cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && !clr && w_push)
         r_mem[r_wr] <= din;
   end

endmodule

// File: rtl/check_scoreboard.sv
// Test-session scoreboard: counts check results, logs failing IDs.
// In: start/end_test, chk_* results, fail_ready. Out: counters, status, fail_* readout.
module check_scoreboard
   import check_scoreboard_pkg::*;
#(
   parameter logic [31:0] END_SIMULATION = DEF_END_SIMULATION,
   parameter int          FAIL_DEPTH     = DEF_FAIL_DEPTH,
   parameter int          ID_WIDTH       = DEF_ID_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                chk_valid,
   input  logic                chk_mode,
   input  logic [ID_WIDTH-1:0] chk_id,
   input  logic [31:0]         chk_value,
   input  logic [31:0]         chk_expected,
   input  logic                end_test,
   output logic [31:0]         tests_done,
   output logic [31:0]         tests_failed,
   output logic                busy,
   output logic                report_valid,
   output logic                all_passed,
   output logic                timeout,
   output logic                fail_valid,
   output logic [ID_WIDTH-1:0] fail_id,
   input  logic                fail_ready,
   output logic                fail_overflow
);

   state_e      r_state;
   state_e      w_next;
   logic [31:0] r_cyc;
   logic [31:0] r_done;
   logic [31:0] r_failed;
   logic        r_timeout;
   logic        r_ovf;

   logic        w_enter_run;
   logic        w_tmo;
   logic        w_count;
   logic        w_chk_fail;
   logic        w_push;
   logic        w_pop;
   logic        w_empty;
   logic        w_full;
   logic [1:0]  w_fail_inc;

   assign w_chk_fail = chk_mode ? (chk_value != chk_expected)
                                : !chk_value[0];

   // A restart in RUN wins over end_test, timeout and the check.
   assign w_count = (r_state == ST_RUN) && chk_valid && !start;
   assign w_tmo   = (r_state == ST_RUN) && !start && !end_test
                 && (r_cyc == END_SIMULATION - 32'd1);

   assign w_push     = w_count && w_chk_fail;
   assign w_pop      = fail_valid && fail_ready;
   assign w_fail_inc = {1'b0, w_push} + {1'b0, w_tmo};

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_enter_run = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next      = ST_RUN;
               w_enter_run = 1'b1;
            end
         end
         ST_RUN: begin
            if (start) begin
               w_next      = ST_RUN;
               w_enter_run = 1'b1;
            end else if (end_test || w_tmo) begin
               w_next = ST_REPORT;
            end
         end
         ST_REPORT: begin
            w_next = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               w_next      = ST_RUN;
               w_enter_run = 1'b1;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || w_enter_run) begin
         r_cyc     <= '0;
         r_done    <= '0;
         r_failed  <= '0;
         r_timeout <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (r_state == ST_RUN) begin
         r_cyc    <= r_cyc + 32'd1;
         r_done   <= sat_add(r_done, {1'b0, w_count});
         r_failed <= sat_add(r_failed, w_fail_inc);
         if (w_tmo)
            r_timeout <= 1'b1;
         if (w_push && w_full && !w_pop)
            r_ovf <= 1'b1;
      end
   end

   fail_fifo #(
      .DEPTH (FAIL_DEPTH),
      .WIDTH (ID_WIDTH)
   ) u_fail_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_enter_run),
      .push  (w_push),
      .din   (chk_id),
      .pop   (w_pop),
      .dout  (fail_id),
      .empty (w_empty),
      .full  (w_full)
   );

   assign fail_valid    = !w_empty;
   assign tests_done    = r_done;
   assign tests_failed  = r_failed;
   assign timeout       = r_timeout;
   assign fail_overflow = r_ovf;
   assign busy          = (r_state == ST_RUN);
   assign report_valid  = (r_state == ST_REPORT);
   assign all_passed    = ((r_state == ST_REPORT) || (r_state == ST_DONE))
                       && (r_failed == '0);

endmodule
